// File: rtl/gyro_pulse_meter.sv
// gyro_pulse_meter: measures high time and rising-to-rising period of an
// asynchronous pulse line in clk cycles. The first rise only arms a
// measurement; every following rise issues one result with a one-cycle
// valid strobe. A measurement that sees no expected edge within TIMEOUT
// cycles is abandoned and the timeout level is raised until the next rise.
//
// Handshake: valid is a single-cycle, push-only strobe with no ready. The
// consumer must capture high_cnt/period_cnt in the cycle valid is high;
// both outputs hold their value between strobes and change only with valid.
//
// The FSM state is kept in state_q (type state_t) so checkers can bind to it.
module gyro_pulse_meter #(
   parameter int W       = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         pwm_in,
   output logic [W-1:0] high_cnt,
   output logic [W-1:0] period_cnt,
   output logic         valid,
   output logic         timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [W-1:0] ONE    = W'(1);
   localparam logic [W-1:0] TO_LIM = W'(TIMEOUT);

   // Registered state
   logic         sync1_q, sync1_d;
   logic         sync2_q, sync2_d;
   logic         s_d_q, s_d_d;
   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] hi_q, hi_d;
   logic [W-1:0] high_cnt_q, high_cnt_d;
   logic [W-1:0] period_cnt_q, period_cnt_d;
   logic         valid_q, valid_d;
   logic         timeout_q, timeout_d;

   // Edge detection on the synchronised level
   logic         s;
   logic         rise;
   logic         fall;
   logic         at_limit;

   assign s    = sync2_q;
   assign rise = s & ~s_d_q;
   assign fall = ~s & s_d_q;

   // Greater-or-equal rather than equality: a fall that lands exactly on the
   // limit moves to LOW with cnt already past TIMEOUT, and the measurement
   // must still be abandoned there instead of letting cnt run on and wrap.
   assign at_limit = (cnt_q >= TO_LIM);

   // Next-state logic: synchroniser, cycle counter and measurement FSM
   always_comb begin
      sync1_d      = pwm_in;
      sync2_d      = sync1_q;
      s_d_d        = s;
      state_d      = state_q;
      cnt_d        = cnt_q;
      hi_d         = hi_q;
      high_cnt_d   = high_cnt_q;
      period_cnt_d = period_cnt_q;
      valid_d      = 1'b0;
      timeout_d    = timeout_q;

      // Counter restarts at 1 on every rise so that the value seen at the
      // following fall/rise is the high time/period directly.
      if (rise) begin
         cnt_d = ONE;
      end else if (state_q != IDLE) begin
         cnt_d = cnt_q + ONE;
      end

      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d   = HIGH;
               timeout_d = 1'b0;
            end
         end
         HIGH: begin
            if (fall) begin
               state_d = LOW;
               hi_d    = cnt_q;
            end else if (at_limit) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end
         end
         LOW: begin
            if (rise) begin
               state_d      = HIGH;
               high_cnt_d   = hi_q;
               period_cnt_d = cnt_q;
               valid_d      = 1'b1;
            end else if (at_limit) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers, asynchronously cleared
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         s_d_q        <= 1'b0;
         state_q      <= IDLE;
         cnt_q        <= '0;
         hi_q         <= '0;
         high_cnt_q   <= '0;
         period_cnt_q <= '0;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         s_d_q        <= s_d_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         high_cnt_q   <= high_cnt_d;
         period_cnt_q <= period_cnt_d;
         valid_q      <= valid_d;
         timeout_q    <= timeout_d;
      end
   end

   assign high_cnt   = high_cnt_q;
   assign period_cnt = period_cnt_q;
   assign valid      = valid_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_gyro_pulse_meter.sv
// tb_gyro_pulse_meter: directed pulse patterns into gyro_pulse_meter. A
// timestamp-based model of the measurement rules predicts the outputs on
// every cycle; literal expectations after each pattern pin the model.
module tb_gyro_pulse_meter;

   localparam int W  = 16;
   localparam int TO = 100;
   localparam int EW = 2 * W + 2;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         reset;
   logic         pwm_in;
   logic [W-1:0] high_cnt;
   logic [W-1:0] period_cnt;
   logic         valid;
   logic         timeout;

   always #5 clk = ~clk;

   gyro_pulse_meter #(.W(W), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .pwm_in     (pwm_in),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .valid      (valid),
      .timeout    (timeout)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int obs_valid = 0;
   logic [EW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- model ----------------
   // Works on the pwm_in level sampled at each clk edge. A sample that is
   // high after a low one is a rise; the meter reports the rise-to-fall and
   // rise-to-rise distances in samples. Results appear two edges after the
   // sample that completes them (synchroniser plus output register).
   initial begin
      int   k;
      int   t_rise;
      int   t_fall;
      bit   armed;
      logic prev;
      logic v;
      logic m_valid;
      logic m_timeout;
      logic [W-1:0] m_high;
      logic [W-1:0] m_period;
      k = 0; t_rise = 0; t_fall = -1; armed = 0; prev = 0;
      m_valid = 0; m_timeout = 0; m_high = '0; m_period = '0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            k = 0; t_rise = 0; t_fall = -1; armed = 0; prev = 0;
            m_valid = 0; m_timeout = 0; m_high = '0; m_period = '0;
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
         end else begin
            v = pwm_in;
            m_valid = 0;
            if (v && !prev) begin
               if (armed && t_fall >= 0) begin
                  m_valid  = 1;
                  m_high   = W'(t_fall - t_rise);
                  m_period = W'(k - t_rise);
               end
               if (!armed) m_timeout = 0;
               armed  = 1;
               t_rise = k;
               t_fall = -1;
            end else if (armed) begin
               if (!v && prev && t_fall < 0) begin
                  t_fall = k;
               end else if (k - t_rise >= TO) begin
                  armed     = 0;
                  m_timeout = 1;
               end
            end
            prev = v;
            k++;
            exp_q.push_back({m_valid, m_timeout, m_high, m_period});
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic [EW-1:0] rec;
      forever begin
         @(negedge clk);
         if (!reset && exp_q.size() >= 3) begin
            rec = exp_q.pop_front();
            if (valid === 1'b1) obs_valid++;
            chk("cyc_valid",      W'(valid),   W'(rec[EW-1]));
            chk("cyc_timeout",    W'(timeout), W'(rec[EW-2]));
            chk("cyc_high_cnt",   high_cnt,    rec[2*W-1:W]);
            chk("cyc_period_cnt", period_cnt,  rec[W-1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = lvl;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, hi);
         drive(1'b0, lo);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      reset  = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Constant low from reset: stays idle, no timeout
      drive(1'b0, 150);
      chk("idle_valid_cnt", W'(obs_valid), W'(0));
      chk("idle_timeout",   W'(timeout),   W'(0));
      chk("idle_high",      high_cnt,      W'(0));
      chk("idle_period",    period_cnt,    W'(0));

      // 10 high / 10 low: first rise only arms
      base = obs_valid;
      wave(10, 10, 5);
      drive(1'b0, 4);
      chk("sq10_count",   W'(obs_valid - base), W'(4));
      chk("sq10_high",    high_cnt,             W'(10));
      chk("sq10_period",  period_cnt,           W'(20));
      chk("sq10_timeout", W'(timeout),          W'(0));

      // 3 high / 17 low
      base = obs_valid;
      wave(3, 17, 5);
      drive(1'b0, 4);
      chk("pwm3_count",  W'(obs_valid - base), W'(5));
      chk("pwm3_high",   high_cnt,             W'(3));
      chk("pwm3_period", period_cnt,           W'(20));

      // Held high: one result for the closing period, then timeout
      base = obs_valid;
      drive(1'b1, 150);
      chk("to_count",   W'(obs_valid - base), W'(1));
      chk("to_timeout", W'(timeout),          W'(1));
      chk("to_high",    high_cnt,             W'(3));
      chk("to_period",  period_cnt,           W'(24));
      drive(1'b0, 10);
      chk("to_hold", W'(timeout), W'(1));
      base = obs_valid;
      wave(5, 15, 2);
      chk("rearm_count",   W'(obs_valid - base), W'(1));
      chk("rearm_timeout", W'(timeout),          W'(0));
      chk("rearm_high",    high_cnt,             W'(5));
      chk("rearm_period",  period_cnt,           W'(20));

      // Rise landing exactly on the limit: rise wins
      base = obs_valid;
      wave(30, 70, 2);
      drive(1'b1, 5);
      chk("edge_count",   W'(obs_valid - base), W'(3));
      chk("edge_high",    high_cnt,             W'(30));
      chk("edge_period",  period_cnt,           W'(100));
      chk("edge_timeout", W'(timeout),          W'(0));

      // Minimum wave: 1 high / 1 low
      base = obs_valid;
      drive(1'b0, 5);
      wave(1, 1, 10);
      drive(1'b0, 3);
      chk("min_count",  W'(obs_valid - base), W'(10));
      chk("min_high",   high_cnt,             W'(1));
      chk("min_period", period_cnt,           W'(2));

      // Reset mid-LOW after good periods
      base = obs_valid;
      wave(4, 6, 3);
      drive(1'b0, 3);
      chk("pre_rst_count",  W'(obs_valid - base), W'(3));
      chk("pre_rst_high",   high_cnt,             W'(4));
      chk("pre_rst_period", period_cnt,           W'(10));
      reset = 1'b1;
      #1;
      chk("rst_valid",   W'(valid),   W'(0));
      chk("rst_timeout", W'(timeout), W'(0));
      chk("rst_high",    high_cnt,    W'(0));
      chk("rst_period",  period_cnt,  W'(0));
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      base = obs_valid;
      drive(1'b0, 5);
      wave(6, 4, 3);
      drive(1'b0, 4);
      chk("post_rst_count",   W'(obs_valid - base), W'(2));
      chk("post_rst_high",    high_cnt,             W'(6));
      chk("post_rst_period",  period_cnt,           W'(10));
      chk("post_rst_timeout", W'(timeout),          W'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
